// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder with valid/ready request/response handshakes,
// programmable wait states and a byte-enabled word array. Optional store log: DMEM_WRLOG_EN.
module dmem_resp #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned WAIT       = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   input  logic        rsp_ready
);

   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        we_q;
   logic [31:2] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  out_of_range;
   logic [31:0]           byte_mask;
   logic [31:0]           old_word;
   logic [31:0]           new_word;
   logic                  mem_wr;
   logic                  accept;

   assign accept       = req_valid && req_ready;
   assign word_idx     = addr_q[DEPTH_LOG2+1:2];
   assign out_of_range = |addr_q[31:DEPTH_LOG2+2];
   assign byte_mask    = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
   assign old_word     = mem[word_idx];
   assign new_word     = (old_word & ~byte_mask) | (wdata_q & byte_mask);
   assign mem_wr       = (state == ST_ACCESS) && we_q && !out_of_range;

   // NOTE: the array has no reset branch; clearing it would need a reset port on every
   // word. Its write is only reachable from ACCESS, and reset forces IDLE asynchronously.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[word_idx] <= new_word;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q      <= req_we;
                  addr_q    <= req_addr[31:2];
                  be_q      <= req_be;
                  wdata_q   <= req_wdata;
                  wait_cnt  <= WAIT_INIT;
                  req_ready <= 1'b0;
                  state     <= (WAIT_INIT != 4'd0) ? ST_WAIT : ST_ACCESS;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // Stores and faulting accesses return a zero word; loads return the full word.
               if (out_of_range) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
               end else if (we_q) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end else begin
                  rsp_rdata <= old_word;
                  rsp_err   <= 1'b0;
               end
               rsp_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef DMEM_WRLOG_EN
   logic [31:0] pc_q;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^req_addr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= '0;
      end else if (accept) begin
         pc_q <= req_pc;
      end
   end

   always @(posedge clk) begin
      if (reset && mem_wr && (be_q != 4'd0)) begin
         $display("@%h: *%h <= %h", pc_q, {addr_q, 2'b00}, new_word);
      end
   end
`else
   logic unused_inputs;

   assign unused_inputs = ^{req_pc, req_addr[1:0]};
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: WAIT=2 instance driven through a scoreboard queue,
// plus a WAIT=0 instance for back-to-back throughput.
module tb_dmem_resp;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset;

   logic        req_valid, req_ready, req_we, rsp_valid, rsp_err, rsp_ready;
   logic [31:0] req_addr, req_wdata, req_pc, rsp_rdata;
   logic [3:0]  req_be;

   logic        w0_req_valid, w0_req_ready, w0_req_we, w0_rsp_valid, w0_rsp_err, w0_rsp_ready;
   logic [31:0] w0_req_addr, w0_req_wdata, w0_req_pc, w0_rsp_rdata;
   logic [3:0]  w0_req_be;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   dmem_resp #(.DEPTH_LOG2(10), .WAIT(2)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .req_pc    (req_pc),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready)
   );

   dmem_resp #(.DEPTH_LOG2(10), .WAIT(0)) u_dut0 (
      .clk       (clk),
      .reset     (reset),
      .req_valid (w0_req_valid),
      .req_ready (w0_req_ready),
      .req_we    (w0_req_we),
      .req_addr  (w0_req_addr),
      .req_be    (w0_req_be),
      .req_wdata (w0_req_wdata),
      .req_pc    (w0_req_pc),
      .rsp_valid (w0_rsp_valid),
      .rsp_rdata (w0_rsp_rdata),
      .rsp_err   (w0_rsp_err),
      .rsp_ready (w0_rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request on the WAIT=2 instance; returns 1ns after the accept edge.
   task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("send_ready_timeout", {31'd0, req_ready}, 32'd1);
         return;
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wdata;
      req_pc    = 32'h1000 + addr;
      if (push) sb_q.push_back('{rdata: exp_rdata, err: exp_err});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'hA5A5_A5A5;
   endtask

   // Wait for the response, check latency (edges after accept) and scoreboard data.
   task automatic collect(input string tag, input int exp_lat);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rsp_valid && n < 50);
      check({tag, "_latency"}, n, exp_lat);
      if (!rsp_valid || sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
      if (rsp_ready) begin
         @(posedge clk);
         #1;
         check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
         check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
      end
   endtask

   initial begin
      int   n;
      int   last;
      int   cnt;
      exp_t e;

      reset        = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_addr     = '0;
      req_be       = '0;
      req_wdata    = '0;
      req_pc       = '0;
      rsp_ready    = 1'b1;
      w0_req_valid = 1'b0;
      w0_req_we    = 1'b0;
      w0_req_addr  = '0;
      w0_req_be    = '0;
      w0_req_wdata = '0;
      w0_req_pc    = '0;
      w0_rsp_ready = 1'b1;

      #12;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      #5 reset = 1'b1;

      // Full-word store then load.
      send(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
      collect("st10", 3);
      send(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      collect("ld10", 3);

      // Byte-enabled merge, then be=0 store that must not alter the word.
      send(1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 1'b1);
      collect("st20_full", 3);
      send(1'b1, 32'h20, 4'b0100, 32'h00AA_0000, 32'h0, 1'b0, 1'b1);
      collect("st20_b2", 3);
      send(1'b0, 32'h20, 4'hF, 32'h0, 32'h11AA_3344, 1'b0, 1'b1);
      collect("ld20_a", 3);
      send(1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
      collect("st20_be0", 3);
      send(1'b0, 32'h20, 4'hF, 32'h0, 32'h11AA_3344, 1'b0, 1'b1);
      collect("ld20_b", 3);

      // Out-of-range load and store must not alias onto word 0.
      send(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
      collect("st0", 3);
      send(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
      collect("ld_oor", 3);
      send(1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
      collect("st_oor", 3);
      send(1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      collect("ld0_after_oor", 3);
      send(1'b0, 32'h3, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      collect("ld3_lsb_be_ignored", 3);

      // Response back-pressure with a pending request on the input.
      rsp_ready = 1'b0;
      send(1'b0, 32'h20, 4'hF, 32'h0, 32'h11AA_3344, 1'b0, 1'b1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rsp_valid && n < 50);
      check("stall_latency", n, 3);
      e = sb_q.pop_front();
      check("stall_rdata", rsp_rdata, e.rdata);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_be    = 4'hF;
      sb_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_valid_held", {31'd0, rsp_valid}, 32'd1);
         check("stall_rdata_held", rsp_rdata, e.rdata);
         check("stall_req_ready_low", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_hs_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("stall_hs_ready_back", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("stall_next_accepted", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      collect("stall_second", 3);

      // Reset during WAIT of a store aborts it and clears outputs immediately.
      send(1'b1, 32'h30, 4'hF, 32'h0000_0005, 32'h0, 1'b0, 1'b1);
      collect("st30", 3);
      send(1'b0, 32'h30, 4'hF, 32'h0, 32'h0000_0005, 1'b0, 1'b1);
      collect("ld30_pre", 3);
      send(1'b1, 32'h30, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort_rsp_rdata", rsp_rdata, 32'd0);
      check("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      send(1'b0, 32'h30, 4'hF, 32'h0, 32'h0000_0005, 1'b0, 1'b1);
      collect("ld30_post_abort", 3);

      // WAIT=0 instance: one store, then back-to-back loads with valid held high.
      @(negedge clk);
      w0_req_valid = 1'b1;
      w0_req_we    = 1'b1;
      w0_req_addr  = 32'h40;
      w0_req_be    = 4'hF;
      w0_req_wdata = 32'h0BAD_CAFE;
      w0_req_pc    = 32'h3004;
      @(posedge clk);
      #1;
      w0_req_valid = 1'b0;
      check("w0_st_busy", {31'd0, w0_req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("w0_st_valid", {31'd0, w0_rsp_valid}, 32'd1);
      check("w0_st_err", {31'd0, w0_rsp_err}, 32'd0);
      @(posedge clk);
      #1;
      check("w0_st_idle", {31'd0, w0_req_ready}, 32'd1);

      @(negedge clk);
      w0_req_valid = 1'b1;
      w0_req_we    = 1'b0;
      w0_req_addr  = 32'h40;
      last = -1;
      cnt  = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (w0_rsp_valid) begin
            check("w0_ld_rdata", w0_rsp_rdata, 32'h0BAD_CAFE);
            if (last >= 0) check("w0_ld_spacing", i - last, 3);
            last = i;
            cnt++;
         end
      end
      w0_req_valid = 1'b0;
      check("w0_ld_count", cnt, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Responder end of the core's data-memory port. Accepts one load/store request at a time from the pipeline's MEM-stage initiator over a valid/ready handshake. Holds the request for a programmable number of wait states, then performs a byte-enabled word access on an internal word-addressed array and returns a response over a second valid/ready handshake. Sits between the MEM stage and its stall logic: `req_ready` and `rsp_valid` feed the stall/hold decision.

## Interface
- `DEPTH_LOG2`, 10: log2 of array depth in 32-bit words; valid byte addresses are 0 to 2^(DEPTH_LOG2+2)-1.
- `WAIT`, 2: wait-state cycles between accept and access, range 0–15.

- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low; all state cleared while low.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — responder can accept; reset value 1.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_addr`  in  32  — byte address; bits [1:0] ignored.
- `req_be`  in  4  — byte enables; bit i selects `wdata[8i+7:8i]`.
- `req_wdata`  in  32  — store data, already lane-aligned.
- `req_pc`  in  32  — PC of the issuing instruction (logging only).
- `rsp_valid`  out  1  — response present; reset value 0.
- `rsp_rdata`  out  32  — load data, full word; reset value 0.
- `rsp_err`  out  1  — address out of range; reset value 0.
- `rsp_ready`  in  1  — initiator takes response.

## Operation
- FSM states are IDLE, WAIT, ACCESS, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch we/addr/be/wdata/pc.
  - Load wait counter with `WAIT`.
  - Go to WAIT if `WAIT`>0, else ACCESS.
- WAIT: `req_ready`=0. Counter decrements each cycle. Go to ACCESS when counter reaches 1.
- ACCESS (one cycle, `req_ready`=0):
  - Word index = addr[DEPTH_LOG2+1:2].
  - Out of range means any addr[31:DEPTH_LOG2+2] bit is set. Out of range: no array write, rdata latched 0, err latched 1.
  - Store: new word = (old & ~M) | (wdata & M), where M is byte-expanded `be`. `be`=0 leaves the word unchanged but still responds. rdata latched 0.
  - Load: rdata latched with the full stored word. `be` is ignored; lane extraction belongs to the WB extender.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_rdata`/`rsp_err` are held stable until the handshake.
  - On `rsp_ready`: go to IDLE, `rsp_valid`=0, `rsp_err`=0.
- No new request is accepted before the response handshake completes. There is at most one transaction outstanding.
- Array contents are not cleared by reset and power up undefined. Only registers and FSM state are reset.
- Reset asserted mid-transaction aborts it: no write occurs unless ACCESS already completed on a prior edge. Outputs return to reset values immediately (asynchronously).

## Timing
- Accept edge = T.
  - ACCESS occupies cycle T+WAIT.
  - `rsp_valid` rises after edge T+WAIT+1.
  - With `rsp_ready` tied high, `rsp_valid` is high for exactly one cycle and `req_ready` returns high after edge T+WAIT+2.
- Throughput: one transaction per WAIT+3 cycles at best.
- A store is visible to a load accepted on any later cycle; there is no forwarding path.
- `req_valid` held high during busy cycles has no effect. Request inputs are don't-care outside the accept cycle.
- Deasserting `reset` is asynchronous to `clk`. The first accept is possible on the first edge with `reset`=1.

## Configuration
- Macro `DMEM_WRLOG_EN`.
- Defined: every committed in-range store with nonzero `be` prints `"@%h: *%h <= %h"` with req_pc, the word-aligned address, and the new merged word. The print happens in the ACCESS cycle.
- Undefined: no simulation output and `req_pc` is unused. Hardware behaviour is identical either way.

## Test plan
- WAIT=2, reset, store addr 0x10, be=4'hF, wdata 0xDEADBEEF, then load 0x10 → `rsp_valid` rises 3 edges after each accept; load `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Word 0x20 holds 0x11223344; store be=4'b0100, wdata 0x00AA0000; load 0x20 → 0x11AA3344. Repeat with be=0 → still 0x11AA3344, store still gets a response.
- Load addr 0x00010000 with DEPTH_LOG2=10 → `rsp_err`=1, `rsp_rdata`=0; a following load 0x0 returns the unchanged content.
- Hold `rsp_ready`=0 for 5 cycles during RESP while `req_valid`=1 → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0 throughout; second request accepted on the cycle after the handshake.
- Assert `reset` low during the WAIT of a store to 0x30 (prior content 0x5) → outputs go to reset values immediately; a later load of 0x30 returns 0x5.
- WAIT=0 back-to-back loads with `rsp_ready`=1 → one response every 3 cycles; with `DMEM_WRLOG_EN` defined, a store with pc 0x3004 prints exactly one log line.
